// File: rtl/handshake_fifo_break_dv_pkg.sv
// Purpose: shared helpers for handshake FIFO and buffer stages (pointer/count width math).
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package handshake_fifo_break_dv_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_SLOTS  = 4;

  // Ceiling log2. Written out so elaboration-time width math matches across tools.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Pointer width for an N-slot ring. It is never zero, so a 1-slot corner case still elaborates.
  function automatic int ptr_width(input int slots);
    return (clog2(slots) < 1) ? 1 : clog2(slots);
  endfunction

  // Occupancy counter width. It must be able to hold the value 'slots' itself.
  function automatic int count_width(input int slots);
    return clog2(slots + 1);
  endfunction

endpackage

// File: rtl/handshake_fifo_break_dv_mem.sv
// Purpose: simple dual-port register array, one synchronous write port and one asynchronous read port.
// Latency: a write lands at the clock edge; a read is combinational from the address.
// Backpressure: none; the caller owns all flow control.
module handshake_fifo_mem
  import handshake_fifo_break_dv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_NUM_SLOTS,
  parameter int ADDR_WIDTH = ptr_width(DEFAULT_NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port. Storage is deliberately left out of reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/handshake_fifo_break_dv.sv
// Purpose: elastic FIFO stage that breaks valid/ready timing between a producer and its consumer.
// Latency: 1 cycle from an accepted push to the token appearing on outs with outs_valid.
// Backpressure: ins_ready drops only when full. There is no bypass, so a pop while full frees a slot for the next cycle.
module handshake_fifo_break_dv
  import handshake_fifo_break_dv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_SLOTS  = DEFAULT_NUM_SLOTS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PTR_W = ptr_width(NUM_SLOTS);
  localparam int CNT_W = count_width(NUM_SLOTS);

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_SLOTS);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // The handshake outputs come only from registered state (and rst), so there is no input-to-output path.
  assign ins_ready  = !rst && (count != FULL_CNT);
  assign outs_valid = (count != '0);
  assign push       = ins_valid && ins_ready;
  assign pop        = outs_valid && outs_ready;

  // Pointers wrap explicitly at the last slot, so non-power-of-two depths stay inside the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy tracking. A push and a pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  handshake_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_SLOTS),
    .ADDR_WIDTH (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (ins),
    .rd_addr (rd_ptr),
    .rd_data (outs)
  );

endmodule

// File: tb/tb_handshake_fifo_break_dv.sv
// Purpose: scoreboard bench for the elastic FIFO stage, with a 4-slot and a 3-slot instance.
// Latency: the model expects a token one cycle after its accepted push.
// Backpressure: the expected ready is derived from the model occupancy and the reset state.
module tb_handshake_fifo_break_dv;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] outs;
  logic        outs_valid;
  logic        outs_ready;

  logic [31:0] s_ins;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_outs;
  logic        s_outs_valid;
  logic        s_oready;

  int          tests = 0;
  int          fails = 0;
  int          pops3 = 0;
  int          timeouts = 0;
  logic        do_final = 1'b0;
  logic        final_done = 1'b0;
  string       phase = "reset";
  logic [31:0] q4[$];
  logic [31:0] q3[$];

  always #5 clk = ~clk;

  handshake_fifo_break_dv #(.DATA_WIDTH(32), .NUM_SLOTS(4)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
  );

  handshake_fifo_break_dv #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut3 (
    .clk(clk), .rst(rst), .ins(s_ins), .ins_valid(s_valid), .ins_ready(s_ready),
    .outs(s_outs), .outs_valid(s_outs_valid), .outs_ready(s_oready)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: compares the DUT against the queue models on the falling edge, then advances the models.
  always @(negedge clk) begin
    logic exp_rdy;
    logic exp_vld;
    logic exp_rdy3;
    logic exp_vld3;
    exp_rdy  = !rst && (q4.size() != 4);
    exp_vld  = (q4.size() != 0);
    exp_rdy3 = !rst && (q3.size() != 3);
    exp_vld3 = (q3.size() != 0);

    check({phase, " ins_ready"}, 32'(ins_ready), 32'(exp_rdy));
    check({phase, " outs_valid"}, 32'(outs_valid), 32'(exp_vld));
    if (exp_vld && outs_valid) check({phase, " outs"}, outs, q4[0]);
    check({phase, " s3 ins_ready"}, 32'(s_ready), 32'(exp_rdy3));
    check({phase, " s3 outs_valid"}, 32'(s_outs_valid), 32'(exp_vld3));
    if (exp_vld3 && s_outs_valid) check({phase, " s3 outs"}, s_outs, q3[0]);

    if (rst) begin
      q4.delete();
      q3.delete();
    end else begin
      if (exp_vld && outs_ready) void'(q4.pop_front());
      if (ins_valid && exp_rdy) q4.push_back(ins);
      if (exp_vld3 && s_oready) begin
        void'(q3.pop_front());
        pops3++;
      end
      if (s_valid && exp_rdy3) q3.push_back(s_ins);
    end

    if (do_final && !final_done) begin
      check("stream pop count", pops3, 32'd21);
      check("wait timeouts", timeouts, 32'd0);
      final_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current offer until it is accepted, within a bounded number of cycles.
  task automatic wait_accept();
    int n;
    n = 0;
    while (!ins_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) timeouts++;
    tick();
  endtask

  // Drain the 4-slot FIFO with the consumer ready, within a bounded number of cycles.
  task automatic drain4();
    int n;
    n = 0;
    ins_valid  = 1'b0;
    outs_ready = 1'b1;
    while (q4.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) timeouts++;
  endtask

  initial begin
    rst        = 1'b1;
    ins        = 32'hDEAD_0001;
    ins_valid  = 1'b1;
    outs_ready = 1'b0;
    s_ins      = 32'h0;
    s_valid    = 1'b0;
    s_oready   = 1'b0;
    repeat (3) tick();
    rst       = 1'b0;
    ins_valid = 1'b0;
    tick();

    // One token waits for the consumer, then leaves.
    phase     = "single";
    ins       = 32'h0001_F7F8;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    repeat (4) tick();
    outs_ready = 1'b1;
    tick();
    outs_ready = 1'b0;
    tick();

    // Fill to capacity, then offer a fifth token while full.
    phase = "fill";
    for (int v = 1; v <= 4; v++) begin
      ins       = 32'(v);
      ins_valid = 1'b1;
      tick();
    end
    ins = 32'd5;
    repeat (3) tick();
    phase      = "full_pop";
    outs_ready = 1'b1;
    wait_accept();
    phase = "drain";
    drain4();
    outs_ready = 1'b0;
    tick();

    // Back-to-back streaming through the 3-slot instance, crossing the pointer wrap several times.
    phase    = "stream";
    s_oready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      s_ins   = 32'(i);
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    s_oready = 1'b0;

    // Random traffic, with a reset that lands while two tokens are stored.
    phase = "random";
    for (int c = 0; c < 1000; c++) begin
      if (c == 500) begin
        drain4();
        outs_ready = 1'b0;
        ins        = 32'hA5A5_0001;
        ins_valid  = 1'b1;
        tick();
        ins = 32'hA5A5_0002;
        tick();
        phase = "mid_reset";
        rst   = 1'b1;
        ins   = 32'hA5A5_0003;
        repeat (2) tick();
        rst       = 1'b0;
        ins_valid = 1'b0;
        tick();
        phase = "random_after_reset";
      end
      ins_valid  = 1'($urandom_range(0, 1));
      outs_ready = 1'($urandom_range(0, 1));
      ins        = $urandom;
      tick();
    end
    phase = "final_drain";
    drain4();
    tick();
    do_final = 1'b1;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
